mem_read_ctrl: RTL

MEM_READ_CTRL -- requirements
Module: mem_read_ctrl

---
 rtl/mem_read_ctrl_pkg.sv | 21 ++
 rtl/mem_read_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/mem_read_ctrl_pkg.sv
// rtl/mem_read_ctrl_pkg.sv - shared widths and state encoding for the burst read controller
package mem_read_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Byte addresses wrap naturally at the top of the 256-byte data memory
    function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/mem_read_ctrl.sv
// rtl/mem_read_ctrl.sv - burst reader: fetches Length bytes from data memory and hands them downstream one at a time
module mem_read_ctrl
    import mem_read_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [LEN_W-1:0]  Length,
    output logic              MemRead,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] DataMemOut,
    output logic [DATA_W-1:0] ByteOut,
    output logic              ByteValid,
    input  logic              ByteReady,
    output logic              Busy,
    output logic              Done
);

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] addrReg;
    logic [ADDR_W-1:0] addrNext;
    logic [LEN_W-1:0]  countReg;
    logic [LEN_W-1:0]  countNext;
    logic [DATA_W-1:0] byteReg;
    logic [DATA_W-1:0] byteNext;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            addrReg  <= '0;
            countReg <= '0;
            byteReg  <= '0;
        end else begin
            state    <= nextState;
            addrReg  <= addrNext;
            countReg <= countNext;
            byteReg  <= byteNext;
        end
    end

    always_comb begin
        nextState = state;
        addrNext  = addrReg;
        countNext = countReg;
        byteNext  = byteReg;
        MemRead   = 1'b0;
        MemAddr   = '0;
        ByteValid = 1'b0;
        Busy      = 1'b1;
        Done      = 1'b0;

        unique case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    if (Length != '0) begin
                        addrNext  = StartAddr;
                        countNext = Length;
                        nextState = ISSUE;
                    end else begin
                        nextState = FIN;
                    end
                end
            end

            ISSUE: begin
                MemRead   = 1'b1;
                MemAddr   = addrReg;
                nextState = WAIT;
            end

            // Synchronous memory returns the byte during this cycle
            WAIT: begin
                byteNext  = DataMemOut;
                nextState = OUT;
            end

            // Hold ByteOut until the consumer takes it
            OUT: begin
                ByteValid = 1'b1;
                if (ByteReady) begin
                    if (countReg == LEN_W'(1)) begin
                        nextState = FIN;
                    end else begin
                        countNext = countReg - LEN_W'(1);
                        addrNext  = nextAddr(addrReg);
                        nextState = ISSUE;
                    end
                end
            end

            FIN: begin
                Done      = 1'b1;
                nextState = IDLE;
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign ByteOut = byteReg;

endmodule
